game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 833333, clk cycles per frame tick (60 Hz at 50 MHz); legal range 2 to 2^20.
REQ-002 Parameter CRASH_TICKS, default 90, frame ticks spent in CRASH before OVER; legal range 1 to 255.
REQ-003 Port clk  input  1  system clock; all state updates on posedge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = reset); one clock domain only.
REQ-005 Port press  input  1  player key, level, already synchronised to clk.
REQ-006 Port collide  input  1  bird/pipe/ground collision, level, sampled each clk.
REQ-007 Port pipe_pass  input  1  one-cycle pulse when bird clears a pipe.
REQ-008 Port state  output  2  IDLE=00, PLAY=01, CRASH=10, OVER=11.
REQ-009 Port running  output  1  high while state is PLAY.
REQ-010 Port tick  output  1  one-cycle frame-tick pulse.
REQ-011 Port flap  output  1  one-cycle flap pulse to bird physics.
REQ-012 Port score  output  8  current score, two BCD digits {tens, ones}.
REQ-013 Port best  output  8  best score since reset, two BCD digits.
REQ-014 Port game_over  output  1  high while state is OVER.

Function
REQ-015 A press edge SHALL be detected as press=1 with a registered copy of press=0; a level held high SHALL produce only one edge.
REQ-016 The tick divider SHALL count 0..TICK_DIV-1 only in PLAY and CRASH, hold its value in IDLE and OVER, and restart at 0 on the IDLE->PLAY transition.
REQ-017 tick SHALL pulse for exactly one cycle, registered, in the cycle after the divider reaches TICK_DIV-1, giving a period of exactly TICK_DIV cycles.
REQ-018 IDLE->PLAY SHALL occur on a press edge; score SHALL clear to 00 on this transition; this press SHALL NOT produce flap.
REQ-019 In PLAY, each press edge SHALL produce flap one cycle later, high for exactly one cycle.
REQ-020 In PLAY, pipe_pass SHALL increment score in BCD: ones 9 wraps to 0 and carries into tens; score saturates at 99.
REQ-021 In PLAY, collide=1 SHALL move the FSM to CRASH on the next edge; when collide and pipe_pass coincide, collide wins and score is unchanged.
REQ-022 On entering CRASH, a crash counter SHALL clear; each tick SHALL increment it; when it reaches CRASH_TICKS, the FSM SHALL move to OVER.
REQ-023 In CRASH, press, collide and pipe_pass SHALL be ignored; flap SHALL stay 0.
REQ-024 On the CRASH->OVER transition, best SHALL load score when score > best (BCD compare, tens then ones); otherwise best SHALL hold.
REQ-025 In OVER, a press edge SHALL move the FSM to IDLE; score SHALL remain visible in OVER and IDLE until the next game starts.
REQ-026 In IDLE and OVER, collide and pipe_pass SHALL be ignored.
REQ-027 All outputs SHALL be registered; running, game_over and state SHALL change in the same cycle as the FSM state register.

Reset
REQ-028 When reset=0, the block SHALL immediately, without waiting for clk, set state=IDLE, score=00, best=00, tick=0, flap=0, running=0, game_over=0, clear the divider and crash counter, and set the press history to 1.
REQ-029 Because the press history resets to 1, a key held through reset release SHALL NOT start a game.
REQ-030 Reset asserted in any state, including mid-CRASH, SHALL abort the game; best SHALL also clear.

Verification (TICK_DIV=4, CRASH_TICKS=3)
REQ-031 Reset released with press held -> state stays 00; release and re-press -> state=01 next cycle, flap=0, score=00.
REQ-032 In PLAY, 12 pipe_pass pulses -> score=0x12; a further 90 pulses -> score=0x99 (saturated); flap pulses once per press edge.
REQ-033 In PLAY, tick period check -> tick high 1 cycle in every 4; held press -> exactly one flap.
REQ-034 In PLAY with score 0x07, collide and pipe_pass in the same cycle -> state=10, score=0x07; after 3 ticks -> state=11, best=0x07, game_over=1.
REQ-035 Second game scoring 0x05 -> best stays 0x07; press edge in OVER -> state=00 with score still 0x05; next press edge -> score=00.
REQ-036 reset=0 mid-CRASH, between clock edges -> all outputs at reset values immediately; no further tick pulses.

Source files
------------

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - flappy-style game FSM with frame tick, BCD score and best score
module game_sequencer #(
  parameter int unsigned TICK_DIV    = 833333,
  parameter int unsigned CRASH_TICKS = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       press,
  input  logic       collide,
  input  logic       pipe_pass,
  output logic [1:0] state,
  output logic       running,
  output logic       tick,
  output logic       flap,
  output logic [7:0] score,
  output logic [7:0] best,
  output logic       game_over
);

  localparam int unsigned   DW        = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_MAX   = DW'(TICK_DIV - 1);
  localparam logic [7:0]    CRASH_MAX = 8'(CRASH_TICKS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_CRASH = 2'b10,
    S_OVER  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic          press_q;
  logic [DW-1:0] div_q, div_d;
  logic          tick_q, tick_d;
  logic          flap_q, flap_d;
  logic [7:0]    crash_q, crash_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    best_q, best_d;
  logic          running_q, running_d;
  logic          over_q, over_d;
  logic          press_edge;

  // BCD increment that saturates at 99
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == 8'h99) begin
      return s;
    end else if (s[3:0] == 4'd9) begin
      return {s[7:4] + 4'd1, 4'd0};
    end else begin
      return {s[7:4], s[3:0] + 4'd1};
    end
  endfunction

  assign press_edge = press & ~press_q;

  // Press history; resets to 1 so a key held through reset release is not an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_q <= 1'b1;
    end else begin
      press_q <= press;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      tick_q    <= 1'b0;
      flap_q    <= 1'b0;
      crash_q   <= 8'h00;
      score_q   <= 8'h00;
      best_q    <= 8'h00;
      running_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      flap_q    <= flap_d;
      crash_q   <= crash_d;
      score_q   <= score_d;
      best_q    <= best_d;
      running_q <= running_d;
      over_q    <= over_d;
    end
  end

  // Next-state, divider, scoring and crash-timer logic
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    flap_d  = 1'b0;
    crash_d = crash_q;
    score_d = score_q;
    best_d  = best_q;

    // divider only runs while a game is in progress (PLAY or CRASH)
    if (state_q == S_PLAY || state_q == S_CRASH) begin
      tick_d = (div_q == DIV_MAX);
      div_d  = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (press_edge) begin
          state_d = S_PLAY;
          score_d = 8'h00;
          div_d   = '0;
        end
      end
      S_PLAY: begin
        flap_d = press_edge;
        if (collide) begin
          state_d = S_CRASH;
          crash_d = 8'h00;
        end else if (pipe_pass) begin
          score_d = bcd_inc(score_q);
        end
      end
      S_CRASH: begin
        if (crash_q == CRASH_MAX) begin
          state_d = S_OVER;
          // packed BCD compares correctly as an unsigned binary value
          if (score_q > best_q) begin
            best_d = score_q;
          end
        end else if (tick_q) begin
          crash_d = crash_q + 8'd1;
        end
      end
      S_OVER: begin
        if (press_edge) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    running_d = (state_d == S_PLAY);
    over_d    = (state_d == S_OVER);
  end

  assign state     = state_q;
  assign running   = running_q;
  assign tick      = tick_q;
  assign flap      = flap_q;
  assign score     = score_q;
  assign best      = best_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - self-checking bench for game_sequencer
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       press = 1'b1;
  logic       collide = 1'b0;
  logic       pipe_pass = 1'b0;
  logic [1:0] state;
  logic       running, tick, flap, game_over;
  logic [7:0] score, best;

  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] sb[$];
  logic       fsb[$];
  logic [7:0] model;
  logic [7:0] exp_s;
  logic       exp_f;

  game_sequencer #(.TICK_DIV(4), .CRASH_TICKS(3)) dut (
    .clk(clk), .reset(reset), .press(press), .collide(collide), .pipe_pass(pipe_pass),
    .state(state), .running(running), .tick(tick), .flap(flap),
    .score(score), .best(best), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_inc(input logic [7:0] s);
    int v;
    logic [3:0] t, o;
    v = s[7:4] * 10 + s[3:0];
    if (v < 99) v = v + 1;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic press_edge_cycle();
    press = 1'b0;
    cyc();
    press = 1'b1;
    cyc();
    press = 1'b0;
  endtask

  task automatic pass_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      pipe_pass = 1'b1;
      model = model_inc(model);
      sb.push_back(model);
      cyc();
      pipe_pass = 1'b0;
      exp_s = sb.pop_front();
      tests_run++;
      if (score !== exp_s) begin
        tests_failed++;
        $display("FAIL score_inc[%0d] got=%h exp=%h", i, score, exp_s);
      end
    end
  endtask

  task automatic wait_over(output int ticks_seen);
    ticks_seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (state == 2'b11) break;
      if (state == 2'b10 && tick) ticks_seen++;
      cyc();
    end
    tests_run++;
    if (state !== 2'b11) begin
      tests_failed++;
      $display("FAIL wait_over timeout state=%b exp=11", state);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; press = 1'b1; collide = 1'b0; pipe_pass = 1'b0;
    #3;
    tests_run++;
    if ({state, running, tick, flap, score, best, game_over} !== 22'd0) begin
      tests_failed++;
      $display("FAIL reset_values got=%h exp=0", {state, running, tick, flap, score, best, game_over});
    end
    repeat (3) cyc();
    reset = 1'b1;
    repeat (5) cyc();
    tests_run++;
    if (state !== 2'b00) begin
      tests_failed++;
      $display("FAIL held_press_start got=%b exp=00", state);
    end
  endtask

  task automatic test_start();
    press = 1'b0;
    cyc();
    press = 1'b1;
    cyc();
    tests_run++;
    if ({state, running, flap, score} !== {2'b01, 1'b1, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL start got st=%b run=%b flap=%b score=%h exp st=01 run=1 flap=0 score=00",
               state, running, flap, score);
    end
    press = 1'b0;
    model = 8'h00;
  endtask

  task automatic test_score();
    pass_pulses(12);
    tests_run++;
    if (score !== 8'h12) begin
      tests_failed++;
      $display("FAIL score_12 got=%h exp=12", score);
    end
    pass_pulses(90);
    tests_run++;
    if (score !== 8'h99) begin
      tests_failed++;
      $display("FAIL score_sat got=%h exp=99", score);
    end
  endtask

  task automatic test_tick_flap();
    int found;
    int flaps;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (tick) begin
        found = 1;
        break;
      end
    end
    tests_run++;
    if (found == 0) begin
      tests_failed++;
      $display("FAIL tick_seen got=0 exp=1");
    end
    for (int k = 1; k <= 12; k++) begin
      cyc();
      tests_run++;
      if (tick !== ((k % 4) == 0)) begin
        tests_failed++;
        $display("FAIL tick_period[%0d] got=%b exp=%b", k, tick, (k % 4) == 0);
      end
    end
    flaps = 0;
    press = 1'b0;
    cyc();
    press = 1'b1;
    fsb.push_back(1'b1);
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (flap) flaps++;
      if (k > 0) fsb.push_back(1'b0);
      exp_f = fsb.pop_front();
      tests_run++;
      if (flap !== exp_f) begin
        tests_failed++;
        $display("FAIL flap_held[%0d] got=%b exp=%b", k, flap, exp_f);
      end
    end
    tests_run++;
    if (flaps != 1) begin
      tests_failed++;
      $display("FAIL flap_count got=%0d exp=1", flaps);
    end
    press = 1'b0;
    cyc();
    press = 1'b1;
    cyc();
    tests_run++;
    if (flap !== 1'b1) begin
      tests_failed++;
      $display("FAIL flap_second got=%b exp=1", flap);
    end
    press = 1'b0;
    cyc();
  endtask

  task automatic test_collide_priority();
    int ticks_seen;
    int flap_seen;
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    press_edge_cycle();
    model = 8'h00;
    tests_run++;
    if (state !== 2'b01 || score !== 8'h00) begin
      tests_failed++;
      $display("FAIL restart got st=%b score=%h exp st=01 score=00", state, score);
    end
    pass_pulses(7);
    collide = 1'b1;
    pipe_pass = 1'b1;
    sb.push_back(8'h07);
    cyc();
    collide = 1'b0;
    pipe_pass = 1'b0;
    exp_s = sb.pop_front();
    tests_run++;
    if (state !== 2'b10 || score !== exp_s) begin
      tests_failed++;
      $display("FAIL collide_wins got st=%b score=%h exp st=10 score=%h", state, score, exp_s);
    end
    ticks_seen = (tick === 1'b1) ? 1 : 0;
    flap_seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (state != 2'b10) break;
      press = ~press;
      collide = 1'b1;
      pipe_pass = 1'b1;
      cyc();
      if (flap) flap_seen++;
      if (state == 2'b10 && tick) ticks_seen++;
    end
    press = 1'b0;
    collide = 1'b0;
    pipe_pass = 1'b0;
    tests_run++;
    if (state !== 2'b11 || game_over !== 1'b1 || running !== 1'b0) begin
      tests_failed++;
      $display("FAIL over_state got st=%b go=%b run=%b exp st=11 go=1 run=0", state, game_over, running);
    end
    tests_run++;
    if (ticks_seen != 3) begin
      tests_failed++;
      $display("FAIL crash_ticks got=%0d exp=3", ticks_seen);
    end
    tests_run++;
    if (best !== 8'h07 || score !== 8'h07) begin
      tests_failed++;
      $display("FAIL best_load got best=%h score=%h exp best=07 score=07", best, score);
    end
    tests_run++;
    if (flap_seen != 0) begin
      tests_failed++;
      $display("FAIL crash_flap got=%0d exp=0", flap_seen);
    end
    cyc();
  endtask

  task automatic test_second_game();
    int ticks_seen;
    press_edge_cycle();
    tests_run++;
    if (state !== 2'b00 || score !== 8'h07) begin
      tests_failed++;
      $display("FAIL over_to_idle got st=%b score=%h exp st=00 score=07", state, score);
    end
    press_edge_cycle();
    model = 8'h00;
    tests_run++;
    if (state !== 2'b01 || score !== 8'h00) begin
      tests_failed++;
      $display("FAIL game2_start got st=%b score=%h exp st=01 score=00", state, score);
    end
    pass_pulses(5);
    collide = 1'b1;
    cyc();
    collide = 1'b0;
    wait_over(ticks_seen);
    pipe_pass = 1'b1;
    collide = 1'b1;
    cyc();
    pipe_pass = 1'b0;
    collide = 1'b0;
    cyc();
    tests_run++;
    if (best !== 8'h07 || score !== 8'h05 || state !== 2'b11) begin
      tests_failed++;
      $display("FAIL best_hold got best=%h score=%h st=%b exp best=07 score=05 st=11", best, score, state);
    end
    press_edge_cycle();
    tests_run++;
    if (state !== 2'b00 || score !== 8'h05) begin
      tests_failed++;
      $display("FAIL idle_score got st=%b score=%h exp st=00 score=05", state, score);
    end
    press_edge_cycle();
    tests_run++;
    if (state !== 2'b01 || score !== 8'h00) begin
      tests_failed++;
      $display("FAIL game3_clear got st=%b score=%h exp st=01 score=00", state, score);
    end
  endtask

  task automatic test_reset_mid_crash();
    int ticks_seen;
    collide = 1'b1;
    cyc();
    collide = 1'b0;
    tests_run++;
    if (state !== 2'b10) begin
      tests_failed++;
      $display("FAIL crash_entry got=%b exp=10", state);
    end
    repeat (2) cyc();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({state, running, tick, flap, score, best, game_over} !== 22'd0) begin
      tests_failed++;
      $display("FAIL async_reset got=%h exp=0", {state, running, tick, flap, score, best, game_over});
    end
    ticks_seen = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (tick) ticks_seen++;
    end
    tests_run++;
    if (ticks_seen != 0 || state !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_hold got ticks=%0d st=%b exp ticks=0 st=00", ticks_seen, state);
    end
    reset = 1'b1;
    repeat (6) cyc();
    tests_run++;
    if (state !== 2'b00 || tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset got st=%b tick=%b exp st=00 tick=0", state, tick);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_score();
    test_tick_flap();
    test_collide_priority();
    test_second_game();
    test_reset_mid_crash();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
